// File: rtl/mac_out_serializer.sv
// rtl/mac_out_serializer.sv - buffers 64-bit result words and emits them as two 32-bit beats per word
// Optional feature macro: MAC_SER_HALF_SWAP_EN (emit the upper half of each word first)
module mac_out_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  logic [63:0]          in_data_i,
    input  logic [7:0]           in_strb_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [31:0]          out_data_o,
    output logic [3:0]           out_strb_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [LEN_WIDTH-1:0] word_cnt_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW-1:0]        PTR_ONE  = AW'(1);
    localparam logic [AW:0]          CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]          CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
`ifdef MAC_SER_HALF_SWAP_EN
    localparam logic HALF_SWAP = 1'b1;
`else
    localparam logic HALF_SWAP = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    // Each entry is {strb, data}; the FIFO head doubles as the output word register.
    logic [71:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [AW:0]          count_q;
    logic                 half_q;
    logic [LEN_WIDTH-1:0] len_q, acc_cnt_q, word_cnt_q;

    logic        fifo_full, fifo_empty;
    logic        push, pop, out_fire, last_word, start_ok;
    logic        upper_sel;
    logic [71:0] head;

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);
    assign start_ok   = (state_q == S_IDLE) && start_i;

    assign in_ready_o  = (state_q == S_RUN) && enable_i && !fifo_full && (acc_cnt_q < len_q);
    assign push        = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == S_RUN) && !fifo_empty;
    assign out_fire    = out_valid_o && out_ready_i && enable_i;
    assign pop         = out_fire && half_q;
    assign last_word   = pop && (word_cnt_q == len_q - LEN_ONE);

    assign head       = mem[rd_ptr_q];
    assign upper_sel  = half_q ^ HALF_SWAP;
    assign out_data_o = !out_valid_o ? 32'h0 : (upper_sel ? head[63:32] : head[31:0]);
    assign out_strb_o = !out_valid_o ? 4'h0  : (upper_sel ? head[71:68] : head[67:64]);

    assign busy_o     = (state_q == S_RUN);
    assign done_o     = (state_q == S_DONE);
    assign word_cnt_o = word_cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (len_i != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (last_word) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            half_q     <= 1'b0;
            len_q      <= '0;
            acc_cnt_q  <= '0;
            word_cnt_q <= '0;
        end else if (enable_i) begin
            state_q <= state_d;
            if (start_ok) begin
                len_q      <= len_i;
                acc_cnt_q  <= '0;
                word_cnt_q <= '0;
                half_q     <= 1'b0;
            end
            if (push) begin
                wr_ptr_q  <= wr_ptr_q + PTR_ONE;
                acc_cnt_q <= acc_cnt_q + LEN_ONE;
            end
            // The word leaves the FIFO only after its second beat is handed off.
            if (out_fire) begin
                half_q <= ~half_q;
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PTR_ONE;
                word_cnt_q <= word_cnt_q + LEN_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= {in_strb_i, in_data_i};
        end
    end

endmodule
